// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard/forwarding controller.
//   slot_t    : one scoreboard entry {v, rn, ld} for an in-flight instruction
//   FWD_RF    : forwarding select value meaning "take the register file"
//   sel_width : width of a forwarding select for a given scoreboard depth
package pipe_pkg;

  typedef struct packed {
    logic       v;
    logic [4:0] rn;
    logic       ld;
  } slot_t;

  localparam int FWD_RF = 0;

  // Selects encode 0 (register file) plus one code per slot.
  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_slot_match.sv
// Youngest-match priority encoder for one source operand.
// Ports:
//   slots   in  : scoreboard, slot 0 = EXE (youngest)
//   src     in  : source register number
//   use_src in  : operand is actually read
//   hit     out : some valid slot writes src
//   idx     out : index of the youngest such slot
//   ld      out : that slot holds a load
module hazard_slot_match
  import pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int IW    = sel_width(DEPTH)
) (
  input  slot_t [DEPTH-1:0] slots,
  input  logic  [4:0]       src,
  input  logic              use_src,
  output logic              hit,
  output logic  [IW-1:0]    idx,
  output logic              ld
);

  // Scan oldest to youngest so the lowest matching index is left standing.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    ld  = 1'b0;
    if (use_src && (src != 5'd0)) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (slots[k].v && (slots[k].rn == src)) begin
          hit = 1'b1;
          idx = IW'(k);
          ld  = slots[k].ld;
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Scoreboard-based hazard and forwarding controller for the in-order pipeline.
// Tracks the destination of every in-flight instruction from EXE to the last
// result-producing stage and derives the ID stall, per-operand forwarding
// selects and saturating performance counters.
// Ports:
//   Clock, Resetn         : rising-edge clock, async active-low reset
//   id_valid              : ID holds a real instruction
//   id_rs, id_rt          : source registers
//   id_use_rs, id_use_rt  : operand is actually read
//   id_wreg, id_m2reg     : ID instruction writes the RF / is a load
//   id_rn                 : ID destination register
//   cnt_clr               : synchronous clear of both counters
//   stall                 : freeze PC and IF/ID, bubble into EXE
//   fwd_a_sel, fwd_b_sel  : 0 = register file, k+1 = result of slot k
//   stall_cnt, issue_cnt  : saturating stall-cycle / issue counters
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int  DEPTH    = 2,
  parameter int  LOAD_LAT = 1,
  parameter int  FWD_EN   = 1,
  parameter int  CNT_W    = 16,
  localparam int SW       = sel_width(DEPTH)
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic [4:0]       id_rn,
  input  logic             cnt_clr,
  output logic             stall,
  output logic [SW-1:0]    fwd_a_sel,
  output logic [SW-1:0]    fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] issue_cnt
);

  slot_t [DEPTH-1:0] slots;
  slot_t             new_slot;
  logic              issue;

  logic              hit_a, hit_b;
  logic [SW-1:0]     idx_a, idx_b;
  logic              ld_a, ld_b;
  logic              haz_a, haz_b;
  logic [SW-1:0]     sel_a, sel_b;

  hazard_slot_match #(.DEPTH(DEPTH), .IW(SW)) u_match_rs (
    .slots   (slots),
    .src     (id_rs),
    .use_src (id_use_rs),
    .hit     (hit_a),
    .idx     (idx_a),
    .ld      (ld_a)
  );

  hazard_slot_match #(.DEPTH(DEPTH), .IW(SW)) u_match_rt (
    .slots   (slots),
    .src     (id_rt),
    .use_src (id_use_rt),
    .hit     (hit_b),
    .idx     (idx_b),
    .ld      (ld_b)
  );

  // Returns {hazard, select}. A load younger than LOAD_LAT has no data yet,
  // so it hazards and leaves the select at the register file.
  function automatic logic [SW:0] resolve(input logic hit,
                                          input logic [SW-1:0] idx,
                                          input logic ld);
    logic          haz;
    logic [SW-1:0] sel;
    haz = 1'b0;
    sel = SW'(FWD_RF);
    if (hit) begin
      if (FWD_EN == 0) begin
        haz = 1'b1;
      end else if (ld && (int'(idx) < LOAD_LAT)) begin
        haz = 1'b1;
      end else begin
        sel = idx + SW'(1);
      end
    end
    return {haz, sel};
  endfunction

  always_comb begin
    {haz_a, sel_a} = resolve(hit_a, idx_a, ld_a);
    {haz_b, sel_b} = resolve(hit_b, idx_b, ld_b);
  end

  assign stall     = id_valid & (haz_a | haz_b);
  assign fwd_a_sel = id_valid ? sel_a : SW'(FWD_RF);
  assign fwd_b_sel = id_valid ? sel_b : SW'(FWD_RF);

  // Writes to $0 never produce a value anyone can depend on, so they are not tracked.
  assign issue = id_valid & ~stall & id_wreg & (id_rn != 5'd0);

  always_comb begin
    new_slot    = '0;
    new_slot.v  = issue;
    new_slot.rn = issue ? id_rn : 5'd0;
    new_slot.ld = issue & id_m2reg;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      slots <= '0;
    end else begin
      slots[0] <= new_slot;
      for (int k = 1; k < DEPTH; k++) begin
        slots[k] <= slots[k-1];
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      issue_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (id_valid && !stall && (issue_cnt != '1)) begin
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench: a forwarding instance and a stall-only instance share
// the ID stimulus; each is checked against a per-register "last issued"
// reference model.
module tb_pipe_hazard_unit;

  localparam int DEPTH    = 2;
  localparam int LOAD_LAT = 1;
  localparam int CW       = 4;
  localparam int SW       = $clog2(DEPTH + 1);
  localparam int MAXC     = (1 << CW) - 1;

  logic          Clock = 1'b0;
  logic          Resetn = 1'b0;
  logic          id_valid, id_use_rs, id_use_rt, id_wreg, id_m2reg, cnt_clr;
  logic [4:0]    id_rs, id_rt, id_rn;

  logic          stall_f, stall_s;
  logic [SW-1:0] fa_f, fb_f, fa_s, fb_s;
  logic [CW-1:0] sc_f, ic_f, sc_s, ic_s;

  pipe_hazard_unit #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .FWD_EN(1), .CNT_W(CW)) dut_f (
    .Clock(Clock), .Resetn(Resetn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
    .id_rn(id_rn), .cnt_clr(cnt_clr), .stall(stall_f), .fwd_a_sel(fa_f), .fwd_b_sel(fb_f),
    .stall_cnt(sc_f), .issue_cnt(ic_f)
  );

  pipe_hazard_unit #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .FWD_EN(0), .CNT_W(CW)) dut_s (
    .Clock(Clock), .Resetn(Resetn), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg), .id_m2reg(id_m2reg),
    .id_rn(id_rn), .cnt_clr(cnt_clr), .stall(stall_s), .fwd_a_sel(fa_s), .fwd_b_sel(fb_s),
    .stall_cnt(sc_s), .issue_cnt(ic_s)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Model: index 0 = forwarding instance, 1 = stall-only instance.
  int last_iss[2][32];
  bit last_ld[2][32];
  int e_sc[2], e_ic[2];
  bit e_stall[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int r = 0; r < 32; r++) begin
        last_iss[m][r] = -1000;
        last_ld[m][r]  = 1'b0;
      end
      e_sc[m] = 0;
      e_ic[m] = 0;
      e_stall[m] = 1'b0;
    end
  endtask

  // Age k of the youngest producer of r: issued at cycle c, it sits in slot cyc-c-1.
  function automatic void op_eval(input int m, input logic use_r, input logic [4:0] r,
                                  output bit hz, output int sel);
    int k;
    hz  = 1'b0;
    sel = 0;
    if (use_r && (r != 5'd0)) begin
      k = cyc - last_iss[m][r] - 1;
      if (k >= 0 && k < DEPTH) begin
        if (m == 1) hz = 1'b1;
        else if (last_ld[m][r] && k < LOAD_LAT) hz = 1'b1;
        else sel = k + 1;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    bit hza, hzb;
    int sa, sb;
    logic [31:0] o_st, o_a, o_b, o_sc, o_ic;
    for (int m = 0; m < 2; m++) begin
      op_eval(m, id_use_rs, id_rs, hza, sa);
      op_eval(m, id_use_rt, id_rt, hzb, sb);
      e_stall[m] = id_valid && (hza || hzb);
      if (m == 0) begin
        o_st = 32'(stall_f); o_a = 32'(fa_f); o_b = 32'(fb_f); o_sc = 32'(sc_f); o_ic = 32'(ic_f);
      end else begin
        o_st = 32'(stall_s); o_a = 32'(fa_s); o_b = 32'(fb_s); o_sc = 32'(sc_s); o_ic = 32'(ic_s);
      end
      chk($sformatf("%s.m%0d.stall", tag, m), o_st, 32'(e_stall[m]));
      if (!(id_valid && hza)) chk($sformatf("%s.m%0d.sel_a", tag, m), o_a, id_valid ? sa : 0);
      if (!(id_valid && hzb)) chk($sformatf("%s.m%0d.sel_b", tag, m), o_b, id_valid ? sb : 0);
      chk($sformatf("%s.m%0d.stall_cnt", tag, m), o_sc, e_sc[m]);
      chk($sformatf("%s.m%0d.issue_cnt", tag, m), o_ic, e_ic[m]);
    end
  endtask

  task automatic settle(input string tag);
    @(negedge Clock);
    check_all(tag);
  endtask

  task automatic advance();
    @(posedge Clock);
    for (int m = 0; m < 2; m++) begin
      if (cnt_clr) begin
        e_sc[m] = 0;
        e_ic[m] = 0;
      end else begin
        if (e_stall[m] && e_sc[m] < MAXC) e_sc[m]++;
        if (id_valid && !e_stall[m] && e_ic[m] < MAXC) e_ic[m]++;
      end
      if (id_valid && !e_stall[m] && id_wreg && id_rn != 5'd0) begin
        last_iss[m][id_rn] = cyc;
        last_ld[m][id_rn]  = id_m2reg;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic step(input string tag);
    settle(tag);
    advance();
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic wr,
                        input logic ld, input logic [4:0] rn);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_wreg = wr; id_m2reg = ld; id_rn = rn;
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) step("drain");
  endtask

  initial begin
    model_reset();
    cnt_clr = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check_all("reset");
    @(negedge Clock);
    Resetn = 1'b1;
    @(posedge Clock);
    #1;

    // Forwarded ALU dependency, then an independent instruction.
    set_id(1, 1, 2, 1, 1, 1, 0, 3);  step("add3");
    set_id(1, 3, 5, 1, 1, 1, 0, 4);  settle("sub_dep");
    chk("alu_fwd_stall", 32'(stall_f), 0);
    chk("alu_fwd_sel_a", 32'(fa_f), 1);
    advance();
    set_id(1, 6, 7, 1, 1, 1, 0, 8);  settle("nondep");
    chk("nondep_sel_a", 32'(fa_f), 0);
    advance();
    drain();

    // Load-use: one stall cycle, then forward from slot 1 on both operands.
    cnt_clr = 1'b1; step("clr"); cnt_clr = 1'b0;
    set_id(1, 0, 0, 1, 0, 1, 1, 3);  step("lw3");
    set_id(1, 3, 3, 1, 1, 1, 0, 4);  settle("ld_use0");
    chk("ld_use_stall", 32'(stall_f), 1);
    advance();
    settle("ld_use1");
    chk("ld_use_released", 32'(stall_f), 0);
    chk("ld_use_sel_a", 32'(fa_f), 2);
    chk("ld_use_sel_b", 32'(fb_f), 2);
    chk("ld_use_stall_cnt", 32'(sc_f), 1);
    advance();
    drain();

    // Stall-only interlock: dependent instruction waits DEPTH cycles.
    set_id(1, 1, 2, 1, 1, 1, 0, 3);  step("s_add3");
    set_id(1, 3, 5, 1, 1, 1, 0, 4);
    settle("s_sub0"); chk("nofwd_stall0", 32'(stall_s), 1); advance();
    settle("s_sub1"); chk("nofwd_stall1", 32'(stall_s), 1); advance();
    settle("s_sub2"); chk("nofwd_stall2", 32'(stall_s), 0); chk("nofwd_sel_a", 32'(fa_s), 0); advance();
    drain();

    // $0 is never a dependency; an unused rt never matches.
    set_id(1, 1, 2, 1, 1, 1, 0, 0);  step("wr_r0");
    set_id(1, 0, 0, 1, 1, 1, 0, 5);  settle("rd_r0");
    chk("r0_stall", 32'(stall_s), 0);
    chk("r0_sel_a", 32'(fa_f), 0);
    advance();
    set_id(1, 9, 5, 1, 0, 1, 0, 6);  settle("rt_unused");
    chk("rt_unused_stall", 32'(stall_s), 0);
    chk("rt_unused_sel_b", 32'(fb_f), 0);
    advance();
    drain();

    // Two producers of $7 in flight: the younger one forwards.
    set_id(1, 1, 2, 1, 1, 1, 0, 7);  step("p7a");
    step("p7b");
    set_id(1, 7, 0, 1, 0, 1, 0, 9);  settle("c7");
    chk("youngest_sel_a", 32'(fa_f), 1);
    advance();
    drain();

    // Saturation, then clear during a stall.
    set_id(1, 5, 5, 1, 1, 1, 0, 5);
    repeat (40) step("sat");
    settle("sat_chk");
    chk("sat_stall_cnt", 32'(sc_s), MAXC);
    chk("sat_issue_cnt", 32'(ic_f), MAXC);
    advance();
    drain();
    set_id(1, 1, 2, 1, 1, 1, 0, 5);  step("clr_prod");
    set_id(1, 5, 0, 1, 0, 1, 0, 6);
    cnt_clr = 1'b1;
    settle("clr_stall");
    chk("clr_during_stall", 32'(stall_s), 1);
    advance();
    cnt_clr = 1'b0;
    settle("clr_after");
    chk("clr_stall_cnt", 32'(sc_s), 0);
    advance();
    drain();

    // Async reset in the middle of a stall.
    set_id(1, 1, 2, 1, 1, 1, 0, 3);  step("r_add3");
    set_id(1, 3, 5, 1, 1, 1, 0, 4);
    #1;
    chk("pre_reset_stall", 32'(stall_s), 1);
    Resetn = 1'b0;
    #1;
    chk("reset_stall_s", 32'(stall_s), 0);
    chk("reset_stall_f", 32'(stall_f), 0);
    chk("reset_sel_a", 32'(fa_f), 0);
    chk("reset_stall_cnt", 32'(sc_s), 0);
    chk("reset_issue_cnt", 32'(ic_f), 0);
    model_reset();
    #1;
    Resetn = 1'b1;
    step("post_reset");

    // Random traffic over a small register set to provoke frequent matches.
    for (int i = 0; i < 600; i++) begin
      set_id(($urandom_range(0, 99) < 85) ? 1'b1 : 1'b0,
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
             5'($urandom_range(0, 7)));
      cnt_clr = ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0;
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
